spi_pixel_assembler: RTL and testbench



---
 rtl/spi_pkg.sv | 19 +
 rtl/pixel_fifo.sv | 72 +++++++
 rtl/spi_pixel_assembler.sv | 130 +++++++++++++
 tb/tb_spi_pixel_assembler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizes for the SPI receive-side pixel path.
// Used by spi_pixel_assembler and its pixel_fifo storage.
package spi_pkg;

  localparam int BYTE_W      = 8;
  localparam int PIXEL_W     = 24;
  localparam int PIXEL_BYTES = 3;
  localparam int FIFO_DEPTH  = 4;
  localparam int LEVEL_W     = 4;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Pixel storage between the byte assembler and the downstream pipeline.
// SPI_PIXEL_FIFO_EN selects a 4-entry FIFO; otherwise a single output register.
module pixel_fifo
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  pixel_t             push_data,
  input  logic               pop,
  output pixel_t             pop_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  logic do_push;
  logic do_pop;

  // A push into full storage is accepted only when a pop frees the slot this same edge.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

`ifdef SPI_PIXEL_FIFO_EN
  pixel_t     mem [FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == 3'(FIFO_DEPTH));
  assign empty    = (count == 3'd0);
  assign level    = {1'b0, count};
`else
  pixel_t data_q;
  logic   valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (do_push) begin
      data_q  <= push_data;
      valid_q <= 1'b1;
    end else if (do_pop) begin
      valid_q <= 1'b0;
    end
  end

  assign pop_data = data_q;
  assign full     = valid_q;
  assign empty    = ~valid_q;
  assign level    = {3'b000, valid_q};
`endif

endmodule

// File: rtl/spi_pixel_assembler.sv
// Syncs SPI byte-done/CS into clk_i, packs R,G,B bytes into pixels, reports status on data_tx_o.
// Storage depth follows SPI_PIXEL_FIFO_EN (see pixel_fifo).
module spi_pixel_assembler
  import spi_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int PIXEL_BYTES = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cs_i,
  input  logic                 rxtx_done_i,
  input  logic [WORD_SIZE-1:0] data_rx_i,
  output logic [WORD_SIZE-1:0] data_tx_o,
  output logic [23:0]          pixel_o,
  output logic                 pixel_valid_o,
  input  logic                 pixel_ready_i,
  output logic                 overflow_o
);

  logic [1:0] cs_sync;
  logic [1:0] done_sync;
  logic       done_q;
  logic       cs_s;
  logic       done_rise;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_sync   <= '0;
      done_sync <= '0;
      done_q    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs_i};
      done_sync <= {done_sync[0], rxtx_done_i};
      done_q    <= done_sync[1];
    end
  end

  assign cs_s      = cs_sync[1];
  assign done_rise = done_sync[1] & ~done_q;

  rx_state_t state;
  rx_state_t next_state;
  logic      capture;

  // A detected done rise wins over CS low in ARMED, so a late CS drop cannot lose the byte.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE:    if (cs_s) next_state = ARMED;
      ARMED: begin
        if (done_rise) begin
          capture    = 1'b1;
          next_state = HOLD;
        end else if (!cs_s) begin
          next_state = IDLE;
        end
      end
      HOLD:    if (!cs_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  logic [WORD_SIZE-1:0] slot_q [PIXEL_BYTES];
  logic [1:0]           byte_idx;
  logic                 push;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      byte_idx <= '0;
      push     <= 1'b0;
      for (int i = 0; i < PIXEL_BYTES; i++) slot_q[i] <= '0;
    end else begin
      state <= next_state;
      push  <= 1'b0;
      if (capture) begin
        slot_q[byte_idx] <= data_rx_i;
        if (byte_idx == 2'(PIXEL_BYTES - 1)) begin
          byte_idx <= '0;
          push     <= 1'b1;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

  // Downstream handshake: a pixel transfers on any clk_i edge where pixel_valid_o and
  // pixel_ready_i are both high; pixel_o holds and valid stays up until that transfer.
  pixel_t               push_data;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [LEVEL_W-1:0]   level;
  logic                 drop;
  logic                 overflow_q;

  assign push_data = {slot_q[0], slot_q[1], slot_q[2]};
  assign pop       = pixel_valid_o & pixel_ready_i;
  assign drop      = push & full & ~pop;

  pixel_fifo u_pixel_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pixel_o),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign pixel_valid_o = ~empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      data_tx_o  <= '0;
    end else begin
      overflow_q <= overflow_q | drop;
      data_tx_o  <= {overflow_q, 3'b000, level};
    end
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_spi_pixel_assembler.sv
// Directed bench for spi_pixel_assembler; expectations adapt to SPI_PIXEL_FIFO_EN.
module tb_spi_pixel_assembler;

`ifdef SPI_PIXEL_FIFO_EN
  localparam int          FULL_N = 4;
  localparam logic [23:0] OVF_TX = 24'h84;
`else
  localparam int          FULL_N = 1;
  localparam logic [23:0] OVF_TX = 24'h81;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cs_i;
  logic        rxtx_done_i;
  logic [7:0]  data_rx_i;
  logic [7:0]  data_tx_o;
  logic [23:0] pixel_o;
  logic        pixel_valid_o;
  logic        pixel_ready_i;
  logic        overflow_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [23:0] pix [5];

  always #5 clk = ~clk;

  spi_pixel_assembler dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .cs_i          (cs_i),
    .rxtx_done_i   (rxtx_done_i),
    .data_rx_i     (data_rx_i),
    .data_tx_o     (data_tx_o),
    .pixel_o       (pixel_o),
    .pixel_valid_o (pixel_valid_o),
    .pixel_ready_i (pixel_ready_i),
    .overflow_o    (overflow_o)
  );

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CS frame; optional done pulse, second done pulse, latency probe, pop on the push edge.
  task automatic send_byte(input logic [7:0] b, input bit with_done, input bit twice,
                           input bit lat_chk, input bit pop_at_push);
    cs_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    data_rx_i = b;
    if (with_done) begin
      rxtx_done_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      if (lat_chk) check("latency_after_capture", {23'b0, pixel_valid_o}, 24'd0);
      if (pop_at_push) pixel_ready_i = 1'b1;
      @(posedge clk);
      #1;
      pixel_ready_i = 1'b0;
      if (lat_chk) check("latency_pixel_visible", {23'b0, pixel_valid_o}, 24'd1);
      repeat (2) @(posedge clk);
      #1;
      rxtx_done_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      if (twice) begin
        data_rx_i   = ~b;
        rxtx_done_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rxtx_done_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
      end
    end else begin
      repeat (10) @(posedge clk);
      #1;
    end
    cs_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] p, input bit lat_chk, input bit pop_at_push);
    send_byte(p[23:16], 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(p[15:8],  1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(p[7:0],   1'b1, 1'b0, lat_chk, pop_at_push);
  endtask

  task automatic pop_expect(input string tag, input logic [23:0] exp);
    check({tag, "_valid"}, {23'b0, pixel_valid_o}, 24'd1);
    check(tag, pixel_o, exp);
    pixel_ready_i = 1'b1;
    @(posedge clk);
    #1;
    pixel_ready_i = 1'b0;
  endtask

  initial begin
    pix[0] = 24'h102030;
    pix[1] = 24'h415263;
    pix[2] = 24'h748596;
    pix[3] = 24'hA7B8C9;
    pix[4] = 24'hDAEBFC;

    reset_i       = 1'b1;
    cs_i          = 1'b0;
    rxtx_done_i   = 1'b0;
    data_rx_i     = 8'h00;
    pixel_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid",    {23'b0, pixel_valid_o}, 24'd0);
    check("reset_pixel",    pixel_o, 24'd0);
    check("reset_overflow", {23'b0, overflow_o}, 24'd0);
    check("reset_tx",       {16'b0, data_tx_o}, 24'd0);
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic pixel, capture latency, hold-while-not-ready, single transfer.
    send_pixel(24'h123456, 1'b1, 1'b0);
    check("basic_tx_level", {16'b0, data_tx_o}, 24'h01);
    check("basic_overflow", {23'b0, overflow_o}, 24'd0);
    repeat (5) @(posedge clk);
    #1;
    check("basic_hold", pixel_o, 24'h123456);
    pop_expect("basic_pixel", 24'h123456);
    check("basic_drained", {23'b0, pixel_valid_o}, 24'd0);

    // Empty frame must not shift byte alignment.
    send_byte(8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pixel(24'hAABBCC, 1'b0, 1'b0);
    pop_expect("empty_frame_pixel", 24'hAABBCC);

    // Second done rise within one frame is ignored.
    send_byte(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    send_byte(8'h6B, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h7C, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_expect("double_done_pixel", 24'h5A6B7C);

    // Reset with a stored pixel and a partial pixel pending.
    send_pixel(pix[0], 1'b0, 1'b0);
    send_byte(8'hDE, 1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hAD, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_valid", {23'b0, pixel_valid_o}, 24'd0);
    check("midreset_pixel", pixel_o, 24'd0);
    check("midreset_tx",    {16'b0, data_tx_o}, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_pixel(24'h010203, 1'b0, 1'b0);
    pop_expect("after_reset_pixel", 24'h010203);

    // Full storage with push and pop on the same edge.
    for (int i = 0; i < FULL_N; i++) send_pixel(pix[i], 1'b0, 1'b0);
    check("full_tx_level", {16'b0, data_tx_o}, 24'(FULL_N));
    send_pixel(pix[FULL_N], 1'b0, 1'b1);
    check("pushpop_overflow", {23'b0, overflow_o}, 24'd0);
    check("pushpop_tx_level", {16'b0, data_tx_o}, 24'(FULL_N));
    for (int i = 1; i <= FULL_N; i++) pop_expect($sformatf("pushpop_drain%0d", i), pix[i]);
    check("pushpop_drained", {23'b0, pixel_valid_o}, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    check("pushpop_tx_empty", {16'b0, data_tx_o}, 24'h00);

    // Overflow: one pixel more than storage holds, nobody popping.
    for (int i = 0; i <= FULL_N; i++) send_pixel(pix[i], 1'b0, 1'b0);
    check("ovf_flag", {23'b0, overflow_o}, 24'd1);
    check("ovf_tx",   {16'b0, data_tx_o}, OVF_TX);
    for (int i = 0; i < FULL_N; i++) pop_expect($sformatf("ovf_drain%0d", i), pix[i]);
    check("ovf_drained", {23'b0, pixel_valid_o}, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_sticky",   {23'b0, overflow_o}, 24'd1);
    check("ovf_tx_empty", {16'b0, data_tx_o}, 24'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
